shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Sequencer that loads a parallel word into a WIDTH-bit flip-flop shift bank and serialises it one bit per enabled tick. Bit order (LSB- or MSB-first) is selectable per word. Upstream writes words through a valid/ready handshake. Downstream sees a serial bit with a qualifying strobe and a done pulse on the last bit. It sits between a parallel producer and any serial sink (LED chain, serial link, display driver).

Parameters:
WIDTH, 8, word length in bits; legal range is WIDTH >= 2.
CNT_W, $clog2(WIDTH), bit-counter width (local, derived).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word available
in_ready  output  1  block can accept a word
in_data  input  WIDTH  parallel word
msb_first  input  1  bit order, sampled with the word (1 = MSB first)
shift_en  input  1  pacing tick; one bit is emitted per high cycle while shifting
abort  input  1  cancel the current word
sout  output  1  serial data bit (registered)
sout_valid  output  1  sout is valid this cycle (registered, one cycle per bit)
busy  output  1  a word is in progress
done  output  1  one-cycle pulse coinciding with the last sout_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge:
  - state goes to IDLE and the counter clears;
  - sout=0, sout_valid=0, busy=0, done=0;
  - in_ready=0 during any cycle where rst is high.
- FSM states: IDLE, SHIFT, LAST.
- IDLE:
  - in_ready = 1 (combinational: state==IDLE & ~rst).
  - On in_valid & in_ready: shift bank <= in_data, order flag <= msb_first, count <= 0, then go to SHIFT.
  - shift_en and abort are ignored.
- SHIFT (busy=1, in_ready=0):
  - On a shift_en cycle:
    - sout <= bank[0] if LSB-first, else bank[WIDTH-1];
    - sout_valid <= 1;
    - the bank shifts toward the emitted end, filling with 0;
    - count increments.
  - When shift_en occurs with count == WIDTH-1, that is the final bit: go to LAST.
  - Cycles without shift_en hold all state; sout_valid <= 0, and sout holds its last value.
- LAST (busy=1):
  - Lasts one cycle.
  - done=1 and sout_valid=1, carrying the final bit registered on entry.
  - Next state is IDLE.
  - busy drops and in_ready rises the cycle after LAST.
- Latency:
  - A handshake in cycle t enters SHIFT at t+1.
  - With shift_en held high, bit k appears on sout in cycle t+2+k.
  - done appears in cycle t+1+WIDTH.
  - The next word can be accepted at t+2+WIDTH.
- abort in SHIFT:
  - Next cycle state is IDLE, sout_valid=0, done=0, and the counter clears.
  - The bank contents are don't-care.
- abort in LAST: ignored; the word completes.
- Simultaneous abort and final shift_en in SHIFT: abort wins; no LAST, no done.
- in_valid while busy: ignored; not back-pressured beyond in_ready=0; no buffering.
- Reset asserted mid-word: the word is discarded; outputs take reset values on the next edge.
- busy = (state != IDLE), decoded from the registered state.
- done = (state == LAST), decoded from the registered state.

Decomposition:
- Shared package constants:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, LAST=2'd2;
  - order encodings: ORDER_LSB=1'b0, ORDER_MSB=1'b1.
- One sub-module, sync_dff_shift_bank: a WIDTH-bit register with synchronous active-high reset, and inputs load, shift, dir, din[WIDTH-1:0].
  - Its output tap is selected by dir.
  - The FSM and counter stay in shift_seq_ctrl.

Test Plan:
- Reset: rst=1 for 3 cycles, with in_valid=1 driven the whole time -> in_ready=0, sout=0, sout_valid=0, busy=0, done=0. After release: in_ready=1, and no word is accepted during reset.
- LSB-first, WIDTH=8: in_data=8'hB1, msb_first=0, shift_en=1 constantly -> sout valid sequence 1,0,0,0,1,1,0,1. done is high only with the 8th bit, in handshake cycle+9. in_ready returns at +10.
- MSB-first with gaps: in_data=8'hB1, msb_first=1, shift_en high every 3rd cycle -> sout valid sequence 1,0,1,1,0,0,0,1. sout_valid is high only the cycle after each shift_en. busy is continuous until done.
- Busy rejection: second in_valid with 8'hFF arriving mid-word -> in_ready=0 and the first word is unchanged. After done, 8'hFF is accepted and emits eight 1s.
- Abort at the final bit: abort=1 together with the 8th shift_en -> done never pulses, sout_valid=0 next cycle, IDLE and in_ready=1 the following cycle. Also: abort during LAST -> done still pulses.
- Reset mid-word: rst=1 after 4 bits of 8'hB1 -> next cycle all outputs are 0. A new word 8'h01 LSB-first then emits 1,0,0,0,0,0,0,0 with count restarted.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the serialising shift sequencer: FSM states and
// the bit-order flag captured with each word.
package shift_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2
  } state_e;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

  // Serial tap for a given bank word and bit order.
  function automatic logic order_tap(input logic dir, input logic lsb_bit,
                                     input logic msb_bit);
    return (dir == ORDER_MSB) ? msb_bit : lsb_bit;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_shift_bank.sv
// WIDTH-bit flip-flop shift bank: parallel load, zero-filling shift toward the
// end selected by dir, and a serial tap on that same end.
module sync_dff_shift_bank
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             tap
);

  logic [WIDTH-1:0] r_bank;

  // Load has priority; the controller never asserts both in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank <= '0;
    end else if (load) begin
      r_bank <= din;
    end else if (shift) begin
      if (dir == ORDER_MSB) begin
        r_bank <= {r_bank[WIDTH-2:0], 1'b0};
      end else begin
        r_bank <= {1'b0, r_bank[WIDTH-1:1]};
      end
    end
  end

  assign tap = order_tap(dir, r_bank[0], r_bank[WIDTH-1]);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Parallel-to-serial sequencer: accepts a word over valid/ready, then emits
// one bit per shift_en tick with a qualifying strobe and a done pulse.
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  input  logic             shift_en,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic             r_order;
  logic [CNT_W-1:0] r_count;
  logic             r_sout;
  logic             r_sout_valid;

  logic w_accept;
  logic w_shift;
  logic w_tap;

  // Valid/ready: a word transfers in any cycle where in_valid and in_ready
  // are both high; in_ready is high only in IDLE outside reset, and words
  // offered while busy are simply not taken (no buffering).
  assign in_ready = (r_state == IDLE) & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_shift  = (r_state == SHIFT) & shift_en & ~abort;

  sync_dff_shift_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .shift(w_shift),
    .dir  (r_order),
    .din  (in_data),
    .tap  (w_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_order      <= ORDER_LSB;
      r_count      <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sout_valid <= 1'b0;
          if (w_accept) begin
            r_order <= msb_first;
            r_count <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // Abort beats a coincident final tick: no LAST, no done.
          if (abort) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_sout_valid <= 1'b0;
          end else if (shift_en) begin
            r_sout       <= w_tap;
            r_sout_valid <= 1'b1;
            r_count      <= r_count + CNT_W'(1);
            if (r_count == LAST_CNT) begin
              r_state <= LAST;
            end
          end else begin
            r_sout_valid <= 1'b0;
          end
        end
        LAST: begin
          r_sout_valid <= 1'b0;
          r_count      <= '0;
          r_state      <= IDLE;
        end
        default: begin
          r_sout_valid <= 1'b0;
          r_count      <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == LAST);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: per-cycle observations of each word are checked
// against a model built from bit positions and shift_en tick times.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         msb_first = 1'b0;
  logic         shift_en = 1'b0;
  logic         abort = 1'b0;
  logic         in_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // Tuple per cycle: {sout_care, in_ready, busy, done, sout_valid, sout}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .msb_first (msb_first),
    .shift_en  (shift_en),
    .abort     (abort),
    .sout      (sout),
    .sout_valid(sout_valid),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Driver: offset 0 is the handshake cycle. shift_en is high on offsets that
  // are multiples of period; abort/rst pulse for one offset; an intruding
  // 8'hFF word is offered for three offsets from intr_off.
  task automatic drive_word(input logic [W-1:0] data, input logic msb,
                            input int period, input int abort_off,
                            input int rst_off, input int intr_off,
                            input int ncyc);
    for (int o = 0; o < ncyc; o++) begin
      @(posedge clk);
      #1;
      in_valid  = (o == 0) || (intr_off >= 0 && o >= intr_off && o < intr_off + 3);
      in_data   = (o == 0) ? data : {W{1'b1}};
      msb_first = (o == 0) ? msb : ~msb;
      shift_en  = ((o % period) == 0);
      abort     = (o == abort_off);
      rst       = (o == rst_off);
      @(negedge clk);
      obs_q.push_back({1'b0, in_ready, busy, done, sout_valid, sout});
    end
  endtask

  // Reference model: bit k is data[k] (LSB-first) or data[W-1-k] (MSB-first),
  // emitted the cycle after the k-th tick seen while the word is in progress.
  task automatic model_word(input logic [W-1:0] data, input logic msb,
                            input int period, input int abort_off,
                            input int rst_off, input int ncyc);
    int   tick_off[W];
    int   nt;
    int   o;
    int   done_off;
    int   end_off;
    logic abort_eff;
    logic vld;
    logic b;
    logic bsy;
    logic rdy;
    logic dn;
    nt = 0;
    o  = 1;
    while (nt < W) begin
      if ((o % period) == 0) begin
        tick_off[nt] = o;
        nt++;
      end
      o++;
    end
    done_off  = tick_off[W-1] + 1;
    abort_eff = (abort_off >= 1) && (abort_off <= tick_off[W-1]);
    end_off   = abort_eff ? abort_off : done_off;
    for (int c = 0; c < ncyc; c++) begin
      if (rst_off >= 0 && c > rst_off) begin
        exp_q.push_back(6'b110000);
      end else begin
        vld = 1'b0;
        b   = 1'b0;
        for (int k = 0; k < W; k++) begin
          if (c == tick_off[k] + 1 && (!abort_eff || tick_off[k] < abort_off)) begin
            vld = 1'b1;
            b   = msb ? data[W-1-k] : data[k];
          end
        end
        bsy = (c >= 1) && (c <= end_off);
        rdy = !bsy && (c != rst_off);
        dn  = !abort_eff && (c == done_off);
        exp_q.push_back({vld, rdy, bsy, dn, vld, b});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hA5; msb_first = 1'b1;
    shift_en = 1'b1; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, sout, sout_valid, busy, done, dbg_state} !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got rdy,sout,vld,busy,done,st=%b required 0000000",
                 i, {in_ready, sout, sout_valid, busy, done, dbg_state});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done, sout_valid} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got rdy,busy,done,vld=%b required 1000",
                 i, {in_ready, busy, done, sout_valid});
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [5:0] e, ob;
    int idx = 0;
    model_word(8'hB1, 1'b0, 1, -1, -1, 11);
    drive_word(8'hB1, 1'b0, 1, -1, -1, -1, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL lsb_first off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  task automatic test_msb_gaps();
    logic [5:0] e, ob;
    int idx = 0;
    model_word(8'hB1, 1'b1, 3, -1, -1, 27);
    drive_word(8'hB1, 1'b1, 3, -1, -1, -1, 27);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL msb_gaps off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  task automatic test_busy_reject();
    logic [5:0] e, ob;
    int idx = 0;
    model_word(8'h3C, 1'b0, 1, -1, -1, 10);
    model_word(8'hFF, 1'b0, 1, -1, -1, 11);
    drive_word(8'h3C, 1'b0, 1, -1, -1, 3, 10);
    drive_word(8'hFF, 1'b0, 1, -1, -1, -1, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL busy_reject off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  task automatic test_abort();
    logic [5:0] e, ob;
    int idx = 0;
    // Abort with the 8th tick (offset 8), then abort during LAST (offset 9).
    model_word(8'hB1, 1'b0, 1, 8, -1, 10);
    model_word(8'hB1, 1'b1, 1, 9, -1, 11);
    drive_word(8'hB1, 1'b0, 1, 8, -1, -1, 10);
    drive_word(8'hB1, 1'b1, 1, 9, -1, -1, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL abort off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e, ob;
    int idx = 0;
    model_word(8'hB1, 1'b0, 1, -1, 6, 9);
    model_word(8'h01, 1'b0, 1, -1, -1, 11);
    drive_word(8'hB1, 1'b0, 1, -1, 6, -1, 9);
    drive_word(8'h01, 1'b0, 1, -1, -1, -1, 11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL reset_mid off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  // Each word starts exactly WIDTH+2 cycles after the previous handshake.
  task automatic test_back_to_back();
    logic [5:0]   e, ob;
    logic [W-1:0] d[3];
    logic         m[3];
    int idx = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = W'($urandom);
      m[i] = 1'($urandom_range(0, 1));
      model_word(d[i], m[i], 1, -1, -1, W + 2);
    end
    for (int i = 0; i < 3; i++) drive_word(d[i], m[i], 1, -1, -1, -1, W + 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
      if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
        errors++;
        $display("FAIL back_to_back off=%0d got rdy,busy,done,vld,sout=%b required %b", idx, ob[4:0], e[4:0]);
      end
      idx++;
    end
  endtask

  task automatic test_random();
    logic [5:0]   e, ob;
    logic [W-1:0] d;
    logic         m;
    int p, ab, n;
    int idx;
    for (int w = 0; w < 10; w++) begin
      d  = W'($urandom);
      m  = 1'($urandom_range(0, 1));
      p  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W * p) : -1;
      n  = W * p + 3;
      model_word(d, m, p, ab, -1, n);
      drive_word(d, m, p, ab, -1, -1, n);
      idx = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); ob = obs_q.pop_front(); checks++;
        if (e[5] ? (ob[4:0] !== e[4:0]) : (ob[4:1] !== e[4:1])) begin
          errors++;
          $display("FAIL random w=%0d data=%h msb=%0d per=%0d abort=%0d off=%0d got %b required %b",
                   w, d, m, p, ab, idx, ob[4:0], e[4:0]);
        end
        idx++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_gaps();
    test_busy_reject();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
